// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial arbiter/sequencer for the single 8-bit RAM port.
// Grants store > load > fetch, sequences 1/2/4-byte transfers, stalls I/O
// writes on a full I/O buffer and aborts speculative reads on roll-back.
// Optional build macro MEM_ARB_FETCH_AGE_EN: after AGE_LIMIT store/load grants
// issued while fetch is waiting, fetch wins the next arbitration.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned AGE_LIMIT  = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  roll_back,
    input  logic                  io_buffer_full,

    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,

    input  logic                  store_req,
    input  logic [ADDR_WIDTH-1:0] store_addr,
    input  logic [1:0]            store_len,
    input  logic [31:0]           store_data,
    output logic                  store_done,

    input  logic                  load_req,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [1:0]            load_len,
    input  logic                  load_signed,
    output logic [31:0]           load_data,
    output logic                  load_done,

    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [31:0]           fetch_data,
    output logic                  fetch_done,

    output logic                  busy
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_STORE = 2'd0,
        OWN_LOAD  = 2'd1,
        OWN_FETCH = 2'd2
    } owner_t;

    // Parameter sanity: I/O decode needs bits [17:16], the age counter needs a nonzero limit
    if (ADDR_WIDTH < 18) begin : g_addr_width_check
        $error("mem_arbiter: ADDR_WIDTH must be at least 18");
    end
    if (AGE_LIMIT == 0) begin : g_age_limit_check
        $error("mem_arbiter: AGE_LIMIT must be at least 1");
    end

    state_t                state;
    owner_t                owner;
    logic [ADDR_WIDTH-1:0] base;
    logic [1:0]            len_q;
    logic                  sign_q;
    logic [31:0]           sdata;
    logic [31:0]           rbuf;
    logic [CNT_W-1:0]      cnt;

    logic [CNT_W-1:0]      nbytes_c;
    logic                  io_stall_c;
    logic [7:0]            wr_byte_c;
    logic [31:0]           rd_word_c;
    logic                  fetch_promote_c;
    logic                  grant_store_c;
    logic                  grant_load_c;
    logic                  grant_fetch_c;

`ifdef MEM_ARB_FETCH_AGE_EN
    localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0] age_cnt;

    assign fetch_promote_c = fetch_req && (age_cnt >= AGE_W'(AGE_LIMIT));

    // Age counter: store/load grants that bypassed a waiting fetch
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            age_cnt <= '0;
        end else if (rdy_in) begin
            if (roll_back || grant_fetch_c) begin
                age_cnt <= '0;
            end else if ((grant_store_c || grant_load_c) && fetch_req
                         && (age_cnt < AGE_W'(AGE_LIMIT))) begin
                age_cnt <= age_cnt + AGE_W'(1);
            end
        end
    end
`else
    assign fetch_promote_c = 1'b0;
`endif

    // Arbitration on requests sampled this edge; never while frozen or flushing
    always_comb begin
        grant_store_c = 1'b0;
        grant_load_c  = 1'b0;
        grant_fetch_c = 1'b0;
        if ((state == S_IDLE) && rdy_in && !roll_back) begin
            if (fetch_promote_c) begin
                grant_fetch_c = 1'b1;
            end else if (store_req) begin
                grant_store_c = 1'b1;
            end else if (load_req) begin
                grant_load_c = 1'b1;
            end else if (fetch_req) begin
                grant_fetch_c = 1'b1;
            end
        end
    end

    // Transfer length in bytes; the reserved code 11 behaves as a word
    always_comb begin
        case (len_q)
            2'b00:   nbytes_c = CNT_W'(1);
            2'b01:   nbytes_c = CNT_W'(2);
            default: nbytes_c = CNT_W'(4);
        endcase
    end

    // I/O region writes wait for room in the I/O buffer
    assign io_stall_c = (base[17:16] == 2'b11) && io_buffer_full;

    // Store byte for the current write step
    always_comb begin
        case (cnt[1:0])
            2'd0:    wr_byte_c = sdata[7:0];
            2'd1:    wr_byte_c = sdata[15:8];
            2'd2:    wr_byte_c = sdata[23:16];
            default: wr_byte_c = sdata[31:24];
        endcase
    end

    // Read buffer with the byte returning this cycle merged in (byte cnt-2)
    always_comb begin
        rd_word_c = rbuf;
        case (cnt)
            3'd2:    rd_word_c[7:0]   = mem_din;
            3'd3:    rd_word_c[15:8]  = mem_din;
            3'd4:    rd_word_c[23:16] = mem_din;
            default: rd_word_c[31:24] = mem_din;
        endcase
    end

    // Sign/zero extension of a load result
    function automatic logic [31:0] extend_word(input logic [31:0] w,
                                                input logic [1:0]  len,
                                                input logic        sgn);
        case (len)
            2'b00:   extend_word = {{24{sgn & w[7]}}, w[7:0]};
            2'b01:   extend_word = {{16{sgn & w[15]}}, w[15:0]};
            default: extend_word = w;
        endcase
    endfunction

    // Sequencer: state, step counter and all registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= S_IDLE;
            owner      <= OWN_STORE;
            base       <= '0;
            len_q      <= 2'b00;
            sign_q     <= 1'b0;
            sdata      <= '0;
            rbuf       <= '0;
            cnt        <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
            store_done <= 1'b0;
            load_done  <= 1'b0;
            fetch_done <= 1'b0;
            load_data  <= '0;
            fetch_data <= '0;
            busy       <= 1'b0;
        end else if (!rdy_in) begin
            // Frozen: a write left on the bus did not land, so step back to re-issue it
            mem_wr <= 1'b0;
            if ((state == S_WRITE) && mem_wr) begin
                cnt <= cnt - CNT_W'(1);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    mem_wr <= 1'b0;
                    cnt    <= '0;
                    if (grant_store_c) begin
                        state <= S_WRITE;
                        owner <= OWN_STORE;
                        base  <= store_addr;
                        len_q <= store_len;
                        sdata <= store_data;
                        busy  <= 1'b1;
                    end else if (grant_load_c) begin
                        state  <= S_READ;
                        owner  <= OWN_LOAD;
                        base   <= load_addr;
                        len_q  <= load_len;
                        sign_q <= load_signed;
                        rbuf   <= '0;
                        busy   <= 1'b1;
                    end else if (grant_fetch_c) begin
                        state  <= S_READ;
                        owner  <= OWN_FETCH;
                        base   <= fetch_addr;
                        len_q  <= 2'b10;
                        sign_q <= 1'b0;
                        rbuf   <= '0;
                        busy   <= 1'b1;
                    end
                end

                S_READ: begin
                    mem_wr <= 1'b0;
                    if (roll_back) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (cnt >= CNT_W'(2)) begin
                            rbuf <= rd_word_c;
                        end
                        if (cnt == nbytes_c + CNT_W'(1)) begin
                            state <= S_DONE;
                            if (owner == OWN_FETCH) begin
                                fetch_data <= rd_word_c;
                                fetch_done <= 1'b1;
                            end else begin
                                load_data <= extend_word(rd_word_c, len_q, sign_q);
                                load_done <= 1'b1;
                            end
                        end else begin
                            if (cnt < nbytes_c) begin
                                mem_a <= base + ADDR_WIDTH'(cnt);
                            end
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                S_WRITE: begin
                    if (cnt == nbytes_c) begin
                        mem_wr     <= 1'b0;
                        state      <= S_DONE;
                        store_done <= 1'b1;
                    end else if (io_stall_c) begin
                        mem_wr <= 1'b0;
                    end else begin
                        mem_wr   <= 1'b1;
                        mem_a    <= base + ADDR_WIDTH'(cnt);
                        mem_dout <= wr_byte_c;
                        cnt      <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    mem_wr     <= 1'b0;
                    store_done <= 1'b0;
                    load_done  <= 1'b0;
                    fetch_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule
